imem_responder: RTL
===================

Name: imem_responder

Overview:
Instruction-memory responder: the slave end of the imem_if fetch interface driven by the IF stage.
- Serves zero-latency instruction reads from a word-organised array.
- Includes a byte-serial boot loader that fills the array after reset, from the testbench or a boot controller.
- Sits beside the core and is the only target of the IF-stage fetch port.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit instruction words (power of two, >= 4)
BASE_ADDR, 32'h0000_0000, byte address of word 0
NOP_INSTR, 32'h0000_0013, word returned for idle, out-of-range or blocked fetches (addi x0,x0,0)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
imem  imem_if.slave  bundle  fetch port: req (in), addr (in, xlen_t), rdata (out, 32)
load_start  input  1  one-cycle pulse that begins a load session
load_valid  input  1  load_byte is valid
load_byte  input  8  program byte, little-endian order
load_last  input  1  qualifies the final byte of the session
load_ready  output  1  responder accepts a byte this cycle
load_busy  output  1  load session in progress
load_done  output  1  one-cycle pulse when the session completes
load_overflow  output  1  sticky: a word was dropped because the array was full
load_words  output  $clog2(DEPTH_WORDS)+1  words written in the current or last session

Behaviour:
Clock and reset:
- One clock, clk. Reset is asynchronous and active-low on rst_n.

Reset values:
- FSM enters IDLE.
- load_ready=0, load_busy=0, load_done=0, load_overflow=0, load_words=0.
- Byte index = 0, assembly register = 0.
- The array is NOT reset; its contents persist across reset.

Fetch path (combinational, zero latency):
- rdata is valid in the same cycle as addr, because the IF stage captures rdata on the edge that follows.
- Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored.
- rdata = mem[index] when all of the following hold: req=1, index < DEPTH_WORDS (unsigned subtraction, with wrap treated as out of range), and load_busy=0.
- Otherwise rdata = NOP_INSTR.

Loader FSM, states IDLE, LOAD, DONE:
- IDLE: on load_start go to LOAD. Clear the byte index, the assembly register, load_words and load_overflow.
- LOAD: load_ready=1 and load_busy=1. A handshake is load_valid && load_ready. Each handshake places load_byte into lane [8*idx +: 8], then idx increments modulo 4.
- Word completion: when the byte at idx==3 is accepted, or load_last is accepted with any idx, write the word.
  - Unfilled upper lanes are zero.
  - Write target is mem[load_words]; load_words then increments.
  - If load_words == DEPTH_WORDS, drop the write, set load_overflow and hold load_words.
- An accepted load_last moves the FSM to DONE.
- DONE: asserts load_done for exactly one cycle with load_ready=0 and load_busy=1, then returns to IDLE.
- Write timing: the array write occurs on the edge of the completing handshake. A fetch of that word returns the new data once the FSM has returned to IDLE.

Boundary cases:
- load_start while in LOAD or DONE: ignored.
- load_valid in IDLE: no effect, since load_ready=0.
- load_start and load_valid in the same IDLE cycle: the byte is not accepted.
- Reset mid-session: the FSM returns to IDLE. Words already written remain; the partial word is lost.
- load_overflow stays set until the next load_start or reset.

Optional Feature:
Macro IMEM_FAULT_EN.
- When defined: adds output fetch_fault (1 bit, reset 0), driven combinationally. It is 1 when req=1 and any of the following holds:
  - addr[1:0] != 0;
  - index >= DEPTH_WORDS;
  - load_busy=1.
- When a fault is flagged, rdata = NOP_INSTR.
- When not defined: the port is absent and misaligned addresses are silently word-aligned.

Test Plan:
1. Reset, then load bytes 13,05,50,00 | 93,05,A0,00 with load_last on the 8th byte:
   - load_done pulses one cycle after the last handshake;
   - load_words=2;
   - fetch addr 0 -> 0x00500513, addr 4 -> 0x00A00593.
2. Load 5 bytes 01,02,03,04,AA with load_last on AA:
   - load_words=2;
   - mem[1]=0x000000AA.
3. DEPTH_WORDS=4, load 20 bytes:
   - load_overflow=1 and load_words=4;
   - mem[0..3] hold the first 16 bytes;
   - fetch addr 0x10 -> 0x00000013.
4. Fetch during LOAD (load_busy=1) at addr 0 -> NOP; fetch with req=0 -> NOP; fetch addr 0x6 -> same data as addr 0x4.
5. Assert rst_n=0 after 2 bytes of a 4-byte session:
   - all outputs return to reset values;
   - previously loaded words still fetch correctly after reset.
6. With IMEM_FAULT_EN defined:
   - addr 0x2 -> fetch_fault=1, rdata=0x00000013;
   - addr 0x0 with valid data -> fetch_fault=0.

Source files
------------

// File: rtl/imem_responder_if.sv
// imem_if: instruction fetch bundle between the IF stage (master) and the
// instruction memory responder (slave).
interface imem_if;
  typedef logic [31:0] xlen_t;

  logic        req;
  xlen_t       addr;
  logic [31:0] rdata;

  modport master (output req, output addr, input rdata);
  modport slave  (input req, input addr, output rdata);
endinterface

// File: rtl/imem_responder.sv
// imem_responder: zero-latency instruction fetch responder with a byte-serial boot loader.
// Optional macro IMEM_FAULT_EN adds fetch_fault for misaligned, out-of-range or blocked fetches.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst_n,
  imem_if.slave                        imem,
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [7:0]                   load_byte,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         load_busy,
  output logic                         load_done,
  output logic                         load_overflow,
  output logic [$clog2(DEPTH_WORDS):0] load_words
`ifdef IMEM_FAULT_EN
  ,
  output logic                         fetch_fault
`endif
);
  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_idx;
  logic [31:0] r_asm;
  logic [31:0] w_asm_next;
  logic [AW:0] r_words;
  logic        r_overflow;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_hs;
  logic        w_word_done;
  logic        w_full;
  logic [29:0] w_word_off;
  logic        w_in_range;
  logic        w_fetch_ok;

  // BASE_ADDR is word-aligned, so the offset is formed on word addresses;
  // a negative offset wraps to a huge index and falls out of range.
  assign w_word_off = imem.addr[31:2] - BASE_ADDR[31:2];
  assign w_in_range = (w_word_off < 30'(DEPTH_WORDS));

`ifdef IMEM_FAULT_EN
  assign fetch_fault = imem.req && ((imem.addr[1:0] != 2'b00) || !w_in_range || load_busy);
  assign w_fetch_ok  = imem.req && !fetch_fault;
`else
  assign w_fetch_ok  = imem.req && w_in_range && !load_busy;
`endif

  assign imem.rdata = w_fetch_ok ? r_mem[w_word_off[AW-1:0]] : NOP_INSTR;

  assign w_hs        = load_valid && load_ready;
  assign w_word_done = (r_idx == 2'd3) || load_last;
  assign w_full      = (r_words == LP_FULL);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_asm_next[8*gi +: 8] = (r_idx == 2'(gi)) ? load_byte : r_asm[8*gi +: 8];
  end

  always_comb begin
    w_state_next = r_state;
    load_ready   = 1'b0;
    load_busy    = 1'b0;
    load_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        load_busy  = 1'b1;
        if (w_hs && load_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        load_busy    = 1'b1;
        load_done    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_asm      <= 32'd0;
      r_words    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && load_start) begin
        r_idx      <= 2'd0;
        r_asm      <= 32'd0;
        r_words    <= '0;
        r_overflow <= 1'b0;
      end else if (w_hs) begin
        r_idx <= r_idx + 2'd1;
        if (w_word_done) begin
          // Clearing the assembly register keeps unfilled lanes of the next word zero.
          r_asm <= 32'd0;
          if (w_full) r_overflow <= 1'b1;
          else        r_words    <= r_words + 1'b1;
        end else begin
          r_asm <= w_asm_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_word_done && !w_full) r_mem[r_words[AW-1:0]] <= w_asm_next;
  end

  assign load_overflow = r_overflow;
  assign load_words    = r_words;
endmodule
